fetch_queue: RTL and testbench

- Instruction prefetch queue sitting directly upstream of the pipelined ARM datapath; produces the Fetch-stage instruction (InstrF) for the current PC.
- Issues sequential word fetches ahead of the PC to a variable-latency, in-order instruction memory and buffers the returned words with their address tags.
- Self-resynchronises when the PC leaves the sequential stream (taken branch, PC write).
- Raises fetch_stall_o so the hazard unit can hold StallF/StallD while the instruction is not yet available.

---
 rtl/fetch_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue feeding InstrF; optional same-cycle bypass under FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        fetch_stall_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_resp_addr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_tag  [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic [31:0]   w_head_tag;
    logic [31:0]   w_head_data;
    logic          w_has;
    logic [31:0]   w_expected;
    logic          w_filling;
    logic          w_resync;
    logic          w_q_valid;
    logic          w_byp;
    logic          w_byp_take;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_accept;
    logic [CW:0]   w_level;
    logic          w_req;
    logic          w_fire;

    assign w_head_tag  = r_tag[r_rd_ptr];
    assign w_head_data = r_data[r_rd_ptr];
    assign w_has       = (r_count != '0);
    assign w_expected  = w_has ? w_head_tag : r_resp_addr;

    // While the queue is empty but live words are still coming back for pc_i, this is normal fill.
    assign w_filling = !w_has && (r_outstanding != r_discard) && (r_resp_addr == pc_i);
    assign w_resync  = (r_state == ST_RUN) && (w_expected != pc_i) && !w_filling;

    assign w_q_valid = w_has && (w_head_tag == pc_i);

`ifdef FETCH_QUEUE_BYPASS_EN
    // A returning word for pc_i may skip the queue when nothing older is buffered or pending discard.
    assign w_byp = reset && !w_has && (r_discard == '0) && imem_rvalid_i && (r_resp_addr == pc_i);
`else
    assign w_byp = 1'b0;
`endif

    assign w_byp_take = w_byp && !stall_i;
    assign w_pop      = w_q_valid && !stall_i;
    assign w_drop     = imem_rvalid_i && (r_discard != '0);
    assign w_accept   = imem_rvalid_i && (r_discard == '0);
    assign w_push     = w_accept && !w_resync && !w_byp_take;

    // Buffered plus in-flight words never exceed DEPTH, so a push always has a free slot.
    assign w_level = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req   = reset && (r_state == ST_RUN) && !w_resync && (w_level < LIMIT);
    assign w_fire  = w_req && imem_gnt_i;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a mismatch enters RESYNC, which always lasts a single cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (w_resync) w_state_next = ST_RESYNC;
            ST_RESYNC: w_state_next = ST_RUN;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // Outputs: fetch request and the Fetch-stage instruction view.
    always_comb begin
        imem_req_o    = w_req;
        imem_addr_o   = r_fetch_addr;
        instr_valid_o = w_q_valid || w_byp;
        instr_o       = 32'h0;
        if (w_q_valid) begin
            instr_o = w_head_data;
        end else if (w_byp) begin
            instr_o = imem_rdata_i;
        end
        fetch_stall_o = !(w_q_valid || w_byp);
    end

    // Request/response bookkeeping, address tracking and queue occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fetch_addr  <= {RESET_PC[31:2], 2'b00};
            r_resp_addr   <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rvalid_i);
            if (w_resync) begin
                r_count      <= '0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_discard    <= r_outstanding - CW'(imem_rvalid_i);
                r_fetch_addr <= {pc_i[31:2], 2'b00};
                r_resp_addr  <= pc_i;
            end else begin
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_drop) r_discard <= r_discard - 1'b1;
                if (w_accept) r_resp_addr <= r_resp_addr + 32'd4;
                if (w_fire) r_fetch_addr <= r_fetch_addr + 32'd4;
            end
        end
    end

    // Queue storage: tag and word written together at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr]  <= r_resp_addr;
            r_data[r_wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with in-order variable-latency memory model
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT1_FIRST = 1;
`else
    localparam int LAT1_FIRST = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        fetch_stall_o;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    int          lat;
    logic        gnt_en;
    logic [31:0] pc;
    logic        stall;
    logic        br_en;
    logic [31:0] br_from;
    logic [31:0] br_to;
    logic        br_seen;
    logic [31:0] br_first_addr;
    int          first_valid_cyc;
    int          last_consume_cyc;
    int          bubbles;
    int          consumed;
    int          n_grants;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: observe at the falling edge, then drive the next cycle's inputs just after the rising edge.
    task automatic step();
        int          lvl;
        logic [31:0] e;
        @(negedge clk);
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_valid = instr_valid_o;
        obs_instr = instr_o;
        lvl = int'(dut.r_count) + mem_q.size() + int'(imem_rvalid_i);
        n_cmp++;
        if (lvl > DEPTH) begin
            n_bad++;
            $display("FAIL level_bound cyc=%0d: got %0d, limit %0d", cyc, lvl, DEPTH);
        end
        n_cmp++;
        if (fetch_stall_o !== ~instr_valid_o) begin
            n_bad++;
            $display("FAIL fetch_stall cyc=%0d: got %b, want %b", cyc, fetch_stall_o, ~instr_valid_o);
        end
        if (imem_req_o === 1'b1 && imem_gnt_i) begin
            n_cmp++;
            if (imem_addr_o[1:0] !== 2'b00) begin
                n_bad++;
                $display("FAIL addr_align cyc=%0d: got %h", cyc, imem_addr_o);
            end
            mem_q.push_back('{addr: imem_addr_o, due: cyc + lat});
            n_grants++;
            if (br_en && pc_i == br_to && !br_seen) begin
                br_seen       = 1'b1;
                br_first_addr = imem_addr_o;
            end
        end
        if (instr_valid_o === 1'b1) begin
            n_cmp++;
            if (instr_o !== mem_word(pc_i)) begin
                n_bad++;
                $display("FAIL instr_for_pc cyc=%0d pc=%h: got %h, want %h", cyc, pc_i, instr_o, mem_word(pc_i));
            end
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!stall_i) begin
                consumed++;
                if (consumed > 1 && cyc != last_consume_cyc + 1) bubbles++;
                last_consume_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_extra cyc=%0d: got %h, want nothing", cyc, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_o !== e) begin
                        n_bad++;
                        $display("FAIL scoreboard_order cyc=%0d: got %h, want %h", cyc, instr_o, e);
                    end
                end
                pc = (br_en && pc == br_from) ? br_to : pc + 32'd4;
            end
        end else begin
            n_cmp++;
            if (instr_o !== 32'h0) begin
                n_bad++;
                $display("FAIL instr_idle cyc=%0d: got %h, want 0", cyc, instr_o);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        imem_gnt_i = gnt_en;
        pc_i       = pc;
        stall_i    = stall;
    endtask

    // Hold reset with random inputs and check the quiet outputs, then release into cycle 0.
    task automatic do_reset(input int l, input logic g);
        reset = 1'b0;
        lat = l;
        gnt_en = g;
        mem_q.delete();
        exp_q.delete();
        pc = 32'h0;
        stall = 1'b0;
        br_en = 1'b0;
        br_seen = 1'b0;
        br_first_addr = '0;
        first_valid_cyc = -1;
        last_consume_cyc = 0;
        bubbles = 0;
        consumed = 0;
        n_grants = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pc_i          = $urandom;
            stall_i       = 1'($urandom_range(0, 1));
            imem_gnt_i    = 1'($urandom_range(0, 1));
            imem_rvalid_i = 1'($urandom_range(0, 1));
            imem_rdata_i  = $urandom;
            @(negedge clk);
            n_cmp++;
            if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || fetch_stall_o !== 1'b1 || instr_o !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got req=%b valid=%b stall=%b instr=%h, want 0/0/1/0",
                         imem_req_o, instr_valid_o, fetch_stall_o, instr_o);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        imem_rvalid_i = 1'b0;
        imem_gnt_i = gnt_en;
        pc_i = pc;
        stall_i = stall;
    endtask

    task automatic run_until(input int n, input string name);
        for (int i = 0; i < 300 && consumed < n; i++) step();
        n_cmp++;
        if (consumed != n || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_done: got %0d consumed (%0d left), want %0d", name, consumed, exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset(1, 1'b1);
        step();
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h, want 1/00000000", obs_req, obs_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset(1, 1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(mem_word(32'(i * 4)));
        run_until(16, "sequential");
        n_cmp++;
        if (first_valid_cyc != LAT1_FIRST) begin
            n_bad++;
            $display("FAIL first_latency: got cycle %0d, want %0d", first_valid_cyc, LAT1_FIRST);
        end
        n_cmp++;
        if (bubbles != 0) begin
            n_bad++;
            $display("FAIL sequential_bubbles: got %0d, want 0", bubbles);
        end
    endtask

    task automatic test_backpressure();
        do_reset(3, 1'b0);
        for (int i = 0; i < 10; i++) exp_q.push_back(mem_word(32'(i * 4)));
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (n_grants != 0 || first_valid_cyc >= 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: got grants=%0d first_valid=%0d, want 0/-1", n_grants, first_valid_cyc);
        end
        gnt_en = 1'b1;
        run_until(10, "backpressure");
    endtask

    task automatic test_branch();
        do_reset(2, 1'b1);
        br_en   = 1'b1;
        br_from = 32'h0000_0008;
        br_to   = 32'h0000_0100;
        exp_q.push_back(mem_word(32'h0));
        exp_q.push_back(mem_word(32'h4));
        exp_q.push_back(mem_word(32'h8));
        for (int i = 0; i < 5; i++) exp_q.push_back(mem_word(32'h100 + 32'(i * 4)));
        run_until(8, "branch");
        n_cmp++;
        if (!br_seen || br_first_addr !== 32'h0000_0100) begin
            n_bad++;
            $display("FAIL branch_refetch: got seen=%b addr=%h, want 1/00000100", br_seen, br_first_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset(1, 1'b1);
        stall = 1'b1;
        stall_i = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(mem_word(32'(i * 4)));
        for (int i = 0; i < 5; i++) step();
        held = mem_word(32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_instr !== held) begin
                n_bad++;
                $display("FAIL stall_full: got req=%b valid=%b instr=%h, want 0/1/%h", obs_req, obs_valid, obs_instr, held);
            end
        end
        n_cmp++;
        if (n_grants != DEPTH) begin
            n_bad++;
            $display("FAIL stall_grants: got %0d, want %0d", n_grants, DEPTH);
        end
        stall = 1'b0;
        run_until(8, "stall_release");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
